// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - LSB-first 2-bit digit-serial adder with single-entry output register
module digit_serial_adder #(
  parameter int MAX_DIGITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_lhs,
  input  logic [1:0] in_rhs,
  input  logic       in_cin,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sum,
  output logic       out_cout,
  output logic       out_last,
  output logic [3:0] out_index,
  output logic       out_err
);

  localparam logic [0:0] FIRST = 1'b0;
  localparam logic [0:0] CHAIN = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(MAX_DIGITS - 1);

  logic [0:0] state;
  logic       carry;
  logic [3:0] count;
  logic       accept;
  logic       cin_eff;
  logic       forced;
  logic       done;
  logic [2:0] digit_sum;

  // in_ready depends only on registered state and out_ready, never on in_valid
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign cin_eff   = (state == CHAIN) ? carry : in_cin;
  assign digit_sum = {1'b0, in_lhs} + {1'b0, in_rhs} + {2'b00, cin_eff};
  // an operand that reaches the last slot without in_last is cut short there
  assign forced    = !in_last && (count == LAST_IDX);
  assign done      = in_last || forced;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FIRST;
      carry     <= 1'b0;
      count     <= 4'd0;
      out_valid <= 1'b0;
      out_sum   <= 2'd0;
      out_cout  <= 1'b0;
      out_last  <= 1'b0;
      out_index <= 4'd0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= digit_sum[1:0];
      out_cout  <= digit_sum[2];
      out_last  <= done;
      out_err   <= forced;
      out_index <= count;
      if (done) begin
        state <= FIRST;
        carry <= 1'b0;
        count <= 4'd0;
      end else begin
        state <= CHAIN;
        carry <= digit_sum[2];
        count <= count + 4'd1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - randomized and directed checks of digit_serial_adder against an integer model
module tb_digit_serial_adder;

  typedef struct packed {
    logic [1:0] lhs;
    logic [1:0] rhs;
    logic       cin;
    logic       last;
  } stim_t;

  typedef struct packed {
    logic [1:0] sum;
    logic       cout;
    logic       last;
    logic [3:0] index;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_lhs = 2'd0;
  logic [1:0] in_rhs = 2'd0;
  logic       in_cin = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       a_in_ready, a_out_valid, a_out_cout, a_out_last, a_out_err;
  logic [1:0] a_out_sum;
  logic [3:0] a_out_index;
  logic       b_in_ready, b_out_valid, b_out_cout, b_out_last, b_out_err;
  logic [1:0] b_out_sum;
  logic [3:0] b_out_index;

  logic       m_in_ready, m_out_valid;
  res_t       m_res;

  int n_checks = 0;
  int n_fail = 0;
  stim_t stim_q[$];
  res_t  exp_q[$];
  res_t  obs_q[$];

  always #5 clk = ~clk;

  digit_serial_adder dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_cin(in_cin), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
    .out_cout(a_out_cout), .out_last(a_out_last), .out_index(a_out_index), .out_err(a_out_err)
  );

  digit_serial_adder #(.MAX_DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_cin(in_cin), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_cout(b_out_cout), .out_last(b_out_last), .out_index(b_out_index), .out_err(b_out_err)
  );

  always_comb begin
    m_in_ready  = sel ? b_in_ready : a_in_ready;
    m_out_valid = sel ? b_out_valid : a_out_valid;
    m_res = sel ? res_t'({b_out_sum, b_out_cout, b_out_last, b_out_index, b_out_err})
                : res_t'({a_out_sum, a_out_cout, a_out_last, a_out_index, a_out_err});
  end

  task automatic push_digit(input int lhs, input int rhs, input int cin, input int last);
    stim_t s;
    s.lhs = 2'(lhs); s.rhs = 2'(rhs); s.cin = 1'(cin); s.last = 1'(last);
    stim_q.push_back(s);
  endtask

  // Each operand segment is summed as whole integers; digit i is read straight out of the total.
  task automatic build_expected(input int max_d);
    longint sa, sb, tot, scin;
    int pos;
    res_t r;
    exp_q.delete();
    pos = 0; sa = 0; sb = 0; scin = 0;
    foreach (stim_q[i]) begin
      if (pos == 0) begin
        sa = 0; sb = 0; scin = longint'(stim_q[i].cin);
      end
      sa  = sa + (longint'(stim_q[i].lhs) << (2 * pos));
      sb  = sb + (longint'(stim_q[i].rhs) << (2 * pos));
      tot = sa + sb + scin;
      r.sum   = 2'((tot >> (2 * pos)) & 3);
      r.cout  = ((tot >> (2 * pos + 2)) & 1) != 0;
      r.index = 4'(pos);
      r.err   = !stim_q[i].last && (pos == max_d - 1);
      r.last  = stim_q[i].last || r.err;
      pos = r.last ? 0 : pos + 1;
      exp_q.push_back(r);
    end
  endtask

  task automatic drive_stream(input int max_d, input bit rand_valid, input bit rand_ready,
                              input int stall_from, input int stall_len, output int cycles);
    int idx, got;
    bit hold;
    res_t held;
    idx = 0; got = 0; cycles = 0; hold = 0; held = '0;
    obs_q.delete();
    build_expected(max_d);
    while (got < exp_q.size() && cycles < 4000) begin
      @(posedge clk); #1;
      cycles++;
      if (idx < stim_q.size() && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_lhs = stim_q[idx].lhs; in_rhs = stim_q[idx].rhs;
        in_cin = stim_q[idx].cin; in_last = stim_q[idx].last;
      end else begin
        in_valid = 1'b0;
      end
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = !(cycles >= stall_from && cycles < stall_from + stall_len);
      @(negedge clk);
      n_checks++;
      if (m_in_ready !== (!m_out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL in_ready_rule: got %b, want %b", m_in_ready, !m_out_valid || out_ready);
      end
      if (hold) begin
        n_checks++;
        if (m_out_valid !== 1'b1 || m_res !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b res=%h, want valid=1 res=%h", m_out_valid, m_res, held);
        end
      end
      hold = m_out_valid && !out_ready;
      held = m_res;
      if (m_out_valid && out_ready) begin
        n_checks++;
        if (m_res !== exp_q[got]) begin
          n_fail++;
          $display("FAIL digit[%0d]: got sum=%0d cout=%b last=%b idx=%0d err=%b, want sum=%0d cout=%b last=%b idx=%0d err=%b",
                   got, m_res.sum, m_res.cout, m_res.last, m_res.index, m_res.err,
                   exp_q[got].sum, exp_q[got].cout, exp_q[got].last, exp_q[got].index, exp_q[got].err);
        end
        obs_q.push_back(m_res);
        got++;
      end
      if (in_valid && m_in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != exp_q.size() || idx != stim_q.size()) begin
      n_fail++;
      $display("FAIL stream_complete: got %0d digits out / %0d in, want %0d / %0d",
               got, idx, exp_q.size(), stim_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_out_sum, a_out_cout, a_out_last, a_out_index, a_out_err} !== 10'd0 ||
        {b_out_valid, b_out_sum, b_out_cout, b_out_last, b_out_index, b_out_err} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b / %b, want all zero",
               {a_out_valid, a_out_sum, a_out_cout, a_out_last, a_out_index, a_out_err},
               {b_out_valid, b_out_sum, b_out_cout, b_out_last, b_out_index, b_out_err});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_single_digit();
    int cyc;
    sel = 1'b0; stim_q.delete();
    push_digit(1, 3, 1, 1);
    drive_stream(8, 0, 0, 0, 0, cyc);
    n_checks++;
    if (obs_q.size() < 1 || obs_q[0] !== res_t'({2'd1, 1'b1, 1'b1, 4'd0, 1'b0})) begin
      n_fail++;
      $display("FAIL single_digit: got %h (n=%0d), want sum=1 cout=1 last=1 idx=0", obs_q.size() ? obs_q[0] : '0, obs_q.size());
    end
  endtask

  task automatic test_four_digits();
    int cyc;
    sel = 1'b0; stim_q.delete();
    push_digit(3, 1, 0, 0); push_digit(3, 0, 0, 0); push_digit(3, 0, 0, 0); push_digit(3, 0, 0, 1);
    drive_stream(8, 0, 0, 0, 0, cyc);
    n_checks++;
    if (cyc != 5) begin
      n_fail++;
      $display("FAIL four_no_bubble: got %0d cycles, want 5", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_q.size() != 4 || obs_q[i] !== res_t'({2'd0, 1'b1, i == 3, 4'(i), 1'b0})) begin
        n_fail++;
        $display("FAIL four_digit[%0d]: got %h, want sum=0 cout=1 last=%0d", i, obs_q.size() == 4 ? obs_q[i] : '0, i == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    sel = 1'b0; stim_q.delete();
    for (int i = 0; i < 4; i++) push_digit($urandom_range(0, 3), $urandom_range(0, 3), 1, i == 3);
    drive_stream(8, 0, 0, 3, 3, cyc);
    n_checks++;
    if (cyc != 8 || obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL backpressure_count: got %0d cycles %0d digits, want 8 cycles 4 digits", cyc, obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    sel = 1'b0; stim_q.delete();
    push_digit(3, 1, 0, 1); push_digit(0, 0, 0, 1);
    drive_stream(8, 0, 0, 0, 0, cyc);
    n_checks++;
    if (obs_q.size() != 2 || obs_q[1].sum !== 2'd0 || obs_q[1].cout !== 1'b0 || obs_q[1].index !== 4'd0) begin
      n_fail++;
      $display("FAIL back_to_back: got %h, want sum=0 cout=0 idx=0", obs_q.size() == 2 ? obs_q[1] : '0);
    end
  endtask

  task automatic test_forced_last();
    int cyc;
    sel = 1'b1; stim_q.delete();
    for (int i = 0; i < 6; i++) push_digit($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), i == 5);
    drive_stream(4, 0, 0, 0, 0, cyc);
    n_checks++;
    if (obs_q.size() != 6 || obs_q[3].last !== 1'b1 || obs_q[3].err !== 1'b1 || obs_q[3].index !== 4'd3) begin
      n_fail++;
      $display("FAIL forced_last: got %h, want idx=3 last=1 err=1", obs_q.size() == 6 ? obs_q[3] : '0);
    end
    n_checks++;
    if (obs_q.size() != 6 || obs_q[4].index !== 4'd0 || obs_q[4].err !== 1'b0 || obs_q[4].last !== 1'b0) begin
      n_fail++;
      $display("FAIL forced_restart: got %h, want idx=0 last=0 err=0", obs_q.size() == 6 ? obs_q[4] : '0);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d, c;
    sel = 1'b0; out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      d = (v == 0) ? 3 : 0;
      c = (v == 0) ? 0 : 1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_lhs = 2'(d); in_rhs = 2'(d); in_cin = 1'b1; in_last = 1'b0;
      @(posedge clk); #1;
      in_cin = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid_flush[%0d]: got valid=%b ready=%b, want 0/1", v, a_out_valid, a_in_ready);
      end
      in_valid = 1'b1; in_lhs = 2'd1; in_rhs = 2'd1; in_cin = 1'(c); in_last = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_sum !== 2'(2 + c) || a_out_cout !== 1'b0 || a_out_index !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_mid_next[%0d]: got v=%b sum=%0d cout=%b idx=%0d, want v=1 sum=%0d cout=0 idx=0",
                 v, a_out_valid, a_out_sum, a_out_cout, a_out_index, 2 + c);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_random(input bit use4, input int nops, input int maxlen);
    int cyc, len;
    sel = use4; stim_q.delete();
    for (int k = 0; k < nops; k++) begin
      len = $urandom_range(1, maxlen);
      for (int i = 0; i < len; i++)
        push_digit($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), i == len - 1);
    end
    drive_stream(use4 ? 4 : 8, 1, 1, 0, 0, cyc);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_four_digits();
    test_backpressure();
    test_back_to_back();
    test_forced_last();
    test_reset_mid();
    test_random(0, 30, 11);
    test_random(1, 20, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter MAX_DIGITS, default 8, meaning the maximum number of 2-bit digits per operand; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream digit pair present.
REQ-005 in_ready  output  1  block accepts the digit pair this cycle.
REQ-006 in_lhs  input  2  LHS operand digit, LSB-first order.
REQ-007 in_rhs  input  2  RHS operand digit, LSB-first order.
REQ-008 in_cin  input  1  carry into digit 0; sampled only on the first digit of an operand.
REQ-009 in_last  input  1  marks the final (most significant) digit.
REQ-010 out_valid  output  1  result digit present.
REQ-011 out_ready  input  1  downstream accepts the result digit.
REQ-012 out_sum  output  2  sum digit.
REQ-013 out_cout  output  1  carry out of this digit; the operand's final carry when out_last=1.
REQ-014 out_last  output  1  result digit is the final digit.
REQ-015 out_index  output  4  digit position of out_sum, 0 = least significant.
REQ-016 out_err  output  1  operand truncated at MAX_DIGITS; valid with out_last.

Function
REQ-017 The block SHALL accept a digit pair when in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL equal (!out_valid || out_ready): single-entry output register, no combinational path from in_valid to in_ready.
REQ-019 Two states SHALL exist: FIRST (next accepted digit is digit 0) and CHAIN (mid-operand).
REQ-020 Carry-in per digit SHALL be in_cin in FIRST and the carry register in CHAIN.
REQ-021 For each accepted digit: {cout,sum} = in_lhs + in_rhs + carry-in (3-bit result); registered to out_sum/out_cout with 1-cycle latency.
REQ-022 An accepted digit SHALL load the carry register with cout and increment the digit counter.
REQ-023 An accepted digit with in_last=1 SHALL set out_last=1, clear the carry register and counter, and move to FIRST.
REQ-024 An accepted digit with in_last=0 SHALL move to or stay in CHAIN.
REQ-025 An accepted digit at index MAX_DIGITS-1 with in_last=0 SHALL be forced last: out_last=1, out_err=1, return to FIRST; the next digit starts a new operand.
REQ-026 out_valid SHALL set on accept.
REQ-027 out_valid SHALL clear on (out_valid && out_ready && no accept).
REQ-028 Simultaneous output drain and input accept SHALL replace the output register in the same cycle with no bubble.
REQ-029 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-030 out_index SHALL equal the counter value at the time the digit was accepted.

Reset
REQ-031 Reset SHALL force out_valid=0, out_sum=0, out_cout=0, out_last=0, out_index=0, out_err=0, carry=0, counter=0, state=FIRST.
REQ-032 in_ready SHALL be 1 in the first cycle after reset.
REQ-033 Reset mid-operand SHALL discard the partial operand and any pending output digit.
REQ-034 After a mid-operand reset, the next accepted digit SHALL be treated as digit 0 and SHALL use in_cin.

Verification
REQ-035 Single digit: lhs=1, rhs=3, cin=1, last=1 -> out_sum=1, out_cout=1, out_last=1, out_index=0 one cycle later.
REQ-036 Four digits, 0xFF+0x01, cin=0, out_ready=1 -> sums 0,0,0,0; cout=1 on each; out_last only on index 3; no bubbles.
REQ-037 Backpressure: out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs stable; resume -> no digit lost or duplicated.
REQ-038 Back-to-back operands: 0x3+0x1 (1 digit), then cin=0, 0x0+0x0 -> second result sum=0, cout=0 (carry not leaked across operands).
REQ-039 MAX_DIGITS=4, five digits with no in_last -> index 3 carries out_last=1, out_err=1; fifth digit emerges as index 0, out_err=0.
REQ-040 Reset asserted after digit 1 of a 4-digit operand -> out_valid=0 next cycle; following digit reports out_index=0 and uses in_cin.
